// File: rtl/lbus_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : lbus_cmd_master
//  Purpose  : Byte-stream command master. Parses write/read frames from an
//             rx byte stream, issues one local bus cycle, and returns an ack
//             byte (write) or four read-data bytes (read) on the tx stream.
//  Revision : 1.0 - initial release
// ============================================================================
module lbus_cmd_master #(
    parameter int          XLEN    = 32,
    parameter logic [2:0]  WE_WORD = 3'b011,
    parameter int          RD_LAT  = 1,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic [7:0]      rx_data,
    input  wire logic            rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  wire logic            tx_ready,
    output logic [XLEN-1:0]      addr,
    output logic [XLEN-1:0]      qin,
    output logic [2:0]           we,
    input  wire logic [XLEN-1:0] qout,
    output logic                 busy,
    output logic                 err
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_ADDR   = 3'd1;
    localparam logic [2:0]  S_DATA   = 3'd2;
    localparam logic [2:0]  S_WRITE  = 3'd3;
    localparam logic [2:0]  S_RDWAIT = 3'd4;
    localparam logic [2:0]  S_RESP   = 3'd5;

    localparam logic [7:0]  c_OP_WR    = 8'h57;
    localparam logic [7:0]  c_OP_RD    = 8'h52;
    localparam logic [7:0]  c_ACK      = 8'h06;
    localparam logic [7:0]  c_LAT_LAST = 8'(RD_LAT - 1);
    localparam logic [15:0] c_TMO_LAST = TIMEOUT - 16'd1;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            w_err_nxt;
    logic            r_err;
    logic            r_armed;
    logic            r_is_wr;
    logic [1:0]      r_cnt;
    logic [15:0]     r_tmo;
    logic [7:0]      r_lat;
    logic [1:0]      r_tx_cnt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_data;
    logic [31:0]     w_word;
    logic            w_rx_ready;
    logic            w_rx_fire;
    logic            w_in_frame;
    logic            w_tmo_hit;
    logic            w_lat_done;
    logic            w_last_tx;

    // The response always carries a 32-bit word, regardless of bus width
    generate
        if (XLEN >= 32) begin : g_word_wide
            assign w_word = r_data[31:0];
        end else begin : g_word_narrow
            assign w_word = {{(32-XLEN){1'b0}}, r_data};
        end
    endgenerate

    // rx is held off until the first clock after reset release
    assign w_rx_ready = r_armed & ((r_state == S_IDLE) | (r_state == S_ADDR) | (r_state == S_DATA));
    assign w_rx_fire  = rx_valid & w_rx_ready;
    assign w_in_frame = (r_state == S_ADDR) | (r_state == S_DATA);
    assign w_tmo_hit  = (r_tmo == c_TMO_LAST);
    assign w_lat_done = (r_lat == c_LAT_LAST);
    assign w_last_tx  = r_is_wr | (r_tx_cnt == 2'd3);

    assign rx_ready = w_rx_ready;
    assign tx_valid = (r_state == S_RESP);
    assign we       = (r_state == S_WRITE) ? WE_WORD : 3'b000;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;
    assign addr     = r_addr;
    assign qin      = r_data;

    // Response byte: ack for writes, read word MSB first for reads
    always_comb begin
        tx_data = 8'h00;
        if (r_state == S_RESP) begin
            if (r_is_wr) begin
                tx_data = c_ACK;
            end else begin
                case (r_tx_cnt)
                    2'd0:    tx_data = w_word[31:24];
                    2'd1:    tx_data = w_word[23:16];
                    2'd2:    tx_data = w_word[15:8];
                    default: tx_data = w_word[7:0];
                endcase
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and error event detection
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    if ((rx_data == c_OP_WR) || (rx_data == c_OP_RD)) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (w_rx_fire) begin
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = r_is_wr ? S_DATA : S_RDWAIT;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DATA: begin
                if (w_rx_fire) begin
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = S_WRITE;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_RESP;
            end
            S_RDWAIT: begin
                if (w_lat_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready && w_last_tx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: shift registers, byte/latency/timeout/tx counters, err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed  <= 1'b0;
            r_err    <= 1'b0;
            r_is_wr  <= 1'b0;
            r_cnt    <= 2'd0;
            r_tmo    <= 16'd0;
            r_lat    <= 8'd0;
            r_tx_cnt <= 2'd0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_armed <= 1'b1;
            r_err   <= w_err_nxt;

            if (r_state == S_IDLE) begin
                r_cnt <= 2'd0;
                if (w_rx_fire) begin
                    r_is_wr <= (rx_data == c_OP_WR);
                end
            end else if (w_in_frame && w_rx_fire) begin
                r_cnt <= r_cnt + 2'd1;
            end

            if ((r_state == S_ADDR) && w_rx_fire) begin
                r_addr <= {r_addr[XLEN-9:0], rx_data};
            end

            if ((r_state == S_DATA) && w_rx_fire) begin
                r_data <= {r_data[XLEN-9:0], rx_data};
            end else if ((r_state == S_RDWAIT) && w_lat_done) begin
                r_data <= qout;
            end

            // Idle counter only runs inside a frame; IDLE keeps it cleared for ADDR entry
            if (!w_in_frame || w_rx_fire) begin
                r_tmo <= 16'd0;
            end else begin
                r_tmo <= r_tmo + 16'd1;
            end

            if (r_state == S_RDWAIT) begin
                r_lat <= r_lat + 8'd1;
            end else begin
                r_lat <= 8'd0;
            end

            if (r_state != S_RESP) begin
                r_tx_cnt <= 2'd0;
            end else if (tx_ready) begin
                r_tx_cnt <= r_tx_cnt + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbus_cmd_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lbus_cmd_master
//  Purpose  : Self-checking bench for lbus_cmd_master: vector table, hand
//             sequences for latency/backpressure/timeout/reset, and random
//             frames checked against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbus_cmd_master;

    localparam int          XLEN    = 32;
    localparam logic [2:0]  WE_WORD = 3'b011;
    localparam int          RD_LAT  = 3;
    localparam logic [15:0] TIMEOUT = 16'd40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] qin;
    logic [2:0]      we;
    logic [XLEN-1:0] qout = '0;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    lbus_cmd_master #(
        .XLEN    (XLEN),
        .WE_WORD (WE_WORD),
        .RD_LAT  (RD_LAT),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .addr     (addr),
        .qin      (qin),
        .we       (we),
        .qout     (qout),
        .busy     (busy),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h0000_1004) ? 32'h1234_5678 : ~a;
    endfunction

    // Bus slave: read data becomes valid RD_LAT cycles after addr settles
    logic [31:0] prev_addr = '0;
    int          addr_age  = 0;
    always @(negedge clk) begin
        if (addr !== prev_addr) addr_age = 1;
        else if (addr_age < 1000) addr_age = addr_age + 1;
        prev_addr = addr;
        qout = (addr_age >= RD_LAT) ? mem_rd(addr) : 32'hBAD0_BAD0;
    end

    // tx sink: 0 = always ready, 1 = random, 2 = stalled
    int tx_mode = 0;
    always @(posedge clk) begin
        #1;
        case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // Observed traffic
    logic [7:0]  got_tx[$];
    logic [31:0] got_wa[$];
    logic [31:0] got_wd[$];
    int          got_err = 0;
    logic        p_err = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
    logic [7:0]  p_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) got_tx.push_back(tx_data);
            if (we != 3'b000) begin
                chk("we_code", we, WE_WORD);
                got_wa.push_back(addr);
                got_wd.push_back(qin);
            end
            if (err) begin
                got_err++;
                chk("err_single_cycle", p_err, 1'b0);
            end
            if (p_valid && !p_ready) begin
                chk("tx_hold_valid", tx_valid, 1'b1);
                chk("tx_hold_data", tx_data, p_data);
            end
            p_err = err; p_valid = tx_valid; p_ready = tx_ready; p_data = tx_data;
        end else begin
            p_err = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_data = 8'h00;
        end
    end

    task automatic clear_got();
        got_tx.delete(); got_wa.delete(); got_wd.delete(); got_err = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("rx_accept_wait", rx_ready, 1'b1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input int maxgap);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int k = 3; k >= 0; k--) begin
                idle_cycles($urandom_range(0, maxgap));
                send_byte(a[8*k +: 8]);
            end
        end
        if (op == 8'h57) begin
            for (int k = 3; k >= 0; k--) begin
                idle_cycles($urandom_range(0, maxgap));
                send_byte(d[8*k +: 8]);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle", busy, 1'b0);
        idle_cycles(2);
    endtask

    // Frame-level reference model
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    int          exp_err = 0;

    task automatic model_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_err = 0;
        w = mem_rd(a);
        if (op == 8'h57) begin
            exp_wa.push_back(a);
            exp_wd.push_back(d);
            exp_tx.push_back(8'h06);
        end else if (op == 8'h52) begin
            for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic compare_model();
        chk("rand_tx_count", got_tx.size(), exp_tx.size());
        for (int k = 0; k < exp_tx.size(); k++)
            chk("rand_tx_byte", (k < got_tx.size()) ? {1'b0, got_tx[k]} : 9'h100, {1'b0, exp_tx[k]});
        chk("rand_wr_count", got_wa.size(), exp_wa.size());
        for (int k = 0; k < exp_wa.size() && k < got_wa.size(); k++) begin
            chk("rand_wr_addr", got_wa[k], exp_wa[k]);
            chk("rand_wr_data", got_wd[k], exp_wd[k]);
        end
        chk("rand_err_count", got_err, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},     addr,     32'h0);
        chk({tag, "_qin"},      qin,      32'h0);
        chk({tag, "_we"},       we,       3'b000);
        chk({tag, "_rx_ready"}, rx_ready, 1'b0);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_tx_data"},  tx_data,  8'h00);
        chk({tag, "_busy"},     busy,     1'b0);
        chk({tag, "_err"},      err,      1'b0);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          n_tx;
        logic [31:0] tx_word;
        int          n_wr;
        int          n_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n;
        int hold_ok;
        logic [7:0] op;

        vecs[0] = '{8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0000_0006, 1, 0};
        vecs[1] = '{8'h52, 32'h0000_1004, 32'h0,         4, 32'h1234_5678, 0, 0};
        vecs[2] = '{8'h41, 32'h0,         32'h0,         0, 32'h0,         0, 1};
        vecs[3] = '{8'h52, 32'hFFFF_0000, 32'h0,         4, 32'h0000_FFFF, 0, 0};
        vecs[4] = '{8'h57, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0006, 1, 0};
        vecs[5] = '{8'h00, 32'h0,         32'h0,         0, 32'h0,         0, 1};
        vecs[6] = '{8'hFF, 32'h0,         32'h0,         0, 32'h0,         0, 1};
        vecs[7] = '{8'h52, 32'h0000_0000, 32'h0,         4, 32'hFFFF_FFFF, 0, 0};

        // Reset state, and rx_ready held low until the first clock after release
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("rx_ready_after_release", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rx_ready_first_clock", rx_ready, 1'b1);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            clear_got();
            send_frame(vecs[v].op, vecs[v].a, vecs[v].d, 2);
            wait_idle();
            chk("vec_tx_count", got_tx.size(), vecs[v].n_tx);
            for (int k = 0; k < vecs[v].n_tx; k++)
                chk("vec_tx_byte", (k < got_tx.size()) ? {1'b0, got_tx[k]} : 9'h100,
                    {1'b0, vecs[v].tx_word[8*(vecs[v].n_tx-1-k) +: 8]});
            chk("vec_wr_count", got_wa.size(), vecs[v].n_wr);
            if (got_wa.size() > 0) begin
                chk("vec_wr_addr", got_wa[0], vecs[v].a);
                chk("vec_wr_data", got_wd[0], vecs[v].d);
            end
            chk("vec_err_count", got_err, vecs[v].n_err);
        end

        // Read latency and a 100-cycle tx stall
        clear_got();
        tx_mode = 2;
        idle_cycles(1);
        send_frame(8'h52, 32'h0000_1004, 32'h0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 20);
        chk("rd_latency_in_range", (n >= RD_LAT && n <= RD_LAT + 1), 1'b1);
        hold_ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h12) hold_ok++;
        end
        chk("stall_hold_cycles", hold_ok, 100);
        tx_mode = 0;
        wait_idle();
        chk("stall_tx_count", got_tx.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("stall_tx_byte", (k < got_tx.size()) ? {1'b0, got_tx[k]} : 9'h100, {1'b0, 8'(8'h12 + 8'h22 * k)});
        chk("stall_wr_count", got_wa.size(), 0);

        // Partial frame then silence: timeout, partial address, no bus write
        clear_got();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err && n < int'(TIMEOUT) + 20);
        chk("timeout_cycles_in_range", (n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 1), 1'b1);
        idle_cycles(1);
        @(negedge clk);
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_partial_addr", addr, 32'h1004_0000);
        chk("timeout_err_count", got_err, 1);
        chk("timeout_wr_count", got_wa.size(), 0);
        idle_cycles(1);
        clear_got();
        send_frame(8'h57, 32'h0000_1004, 32'hDEAD_BEEF, 0);
        wait_idle();
        chk("post_timeout_wr_count", got_wa.size(), 1);
        if (got_wa.size() > 0) begin
            chk("post_timeout_wr_addr", got_wa[0], 32'h0000_1004);
            chk("post_timeout_wr_data", got_wd[0], 32'hDEAD_BEEF);
        end
        chk("post_timeout_tx_count", got_tx.size(), 1);
        if (got_tx.size() > 0) chk("post_timeout_ack", got_tx[0], 8'h06);

        // Reset during the data phase of a write
        clear_got();
        send_byte(8'h57);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h11); send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midframe_rx_ready_release", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        idle_cycles(3);
        chk("midframe_wr_count", got_wa.size(), 0);
        chk("midframe_tx_count", got_tx.size(), 0);
        clear_got();
        send_frame(8'h52, 32'h0000_1004, 32'h0, 0);
        wait_idle();
        chk("post_reset_tx_count", got_tx.size(), 4);
        if (got_tx.size() == 4)
            chk("post_reset_word", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h1234_5678);

        // Random frames against the reference model
        tx_mode = 1;
        for (int f = 0; f < 30; f++) begin
            logic [31:0] ra;
            logic [31:0] rd;
            int sel;
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rd  = $urandom;
            if (sel < 4)      op = 8'h57;
            else if (sel < 8) op = 8'h52;
            else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = 8'h99;
            end
            clear_got();
            model_frame(op, ra, rd);
            send_frame(op, ra, rd, 3);
            wait_idle();
            compare_model();
        end
        tx_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
